fetch_unit: RTL

Instruction fetch stage directly upstream of the decoder. It issues word-aligned requests on the instruction memory bus and buffers the returned words in a small FIFO. An aligner extracts 32-bit and 16-bit (compressed) instructions, which it presents with their PC on a valid/ready interface. Jumps and taken branches redirect it, and it discards stale in-flight responses.

---
 rtl/fetch_unit_if.sv | 47 ++++
 rtl/fetch_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Bundles the instruction-memory bus, the redirect request and
//                the decoder-facing valid/ready handshake of fetch_unit.
//                modport master : the fetch unit side
//                modport slave  : memory + decoder + branch-unit side
//  Signals     : instr_req_o/instr_addr_o/instr_gnt_i      request channel
//                instr_rvalid_i/instr_rdata_i              in-order responses
//                redirect_i/redirect_pc_i                  jump/branch redirect
//                fetch_valid_o/fetch_ready_i/fetch_instr_o/fetch_addr_o
//                                                          decoder handshake
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int RISCV_ADDR_WIDTH = 32,
    parameter int RISCV_WORD_WIDTH = 32
);
    logic                        instr_req_o;
    logic [RISCV_ADDR_WIDTH-1:0] instr_addr_o;
    logic                        instr_gnt_i;
    logic                        instr_rvalid_i;
    logic [RISCV_WORD_WIDTH-1:0] instr_rdata_i;
    logic                        redirect_i;
    logic [RISCV_ADDR_WIDTH-1:0] redirect_pc_i;
    logic                        fetch_valid_o;
    logic                        fetch_ready_i;
    logic [RISCV_WORD_WIDTH-1:0] fetch_instr_o;
    logic [RISCV_ADDR_WIDTH-1:0] fetch_addr_o;

    modport master (
        output instr_req_o, instr_addr_o,
        input  instr_gnt_i, instr_rvalid_i, instr_rdata_i,
        input  redirect_i, redirect_pc_i,
        output fetch_valid_o, fetch_instr_o, fetch_addr_o,
        input  fetch_ready_i
    );

    modport slave (
        input  instr_req_o, instr_addr_o,
        output instr_gnt_i, instr_rvalid_i, instr_rdata_i,
        output redirect_i, redirect_pc_i,
        input  fetch_valid_o, fetch_instr_o, fetch_addr_o,
        output fetch_ready_i
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Issues word-aligned requests, buffers
//                returned words in a prefetch FIFO, and aligns 32-bit and
//                16-bit (compressed) instructions for the decoder. Redirects
//                flush the FIFO and discard responses still in flight.
//  Ports       : clk  - clock
//                rst  - asynchronous reset, active-high
//                bus  - fetch_unit_if.master (memory bus, redirect, decoder)
//  Parameters  : FIFO_DEPTH - prefetch FIFO words (power of 2, >= 2)
//                RESET_PC   - PC after reset (halfword aligned)
//  Macro       : FETCH_COMPRESSED_EN - when defined, RVC alignment is built;
//                otherwise every head word is one 32-bit instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input wire           clk,
    input wire           rst,
    fetch_unit_if.master bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("fetch_unit: FIFO_DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]      pc;
    logic [31:0]      req_addr;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] fifo_count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [31:0]      fifo_mem [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Request / response bookkeeping
    // ------------------------------------------------------------------
    logic [CNT_W:0]   in_flight;
    logic             req;
    logic             issue;
    logic             resp;
    logic             drop;
    logic             push;
    logic [CNT_W-1:0] outstanding_nxt;
    logic [31:0]      pc_target;
    logic [31:0]      addr_target;

    // Words already requested plus words buffered never exceed the FIFO,
    // so every accepted response is guaranteed a free slot.
    assign in_flight       = {1'b0, outstanding} + {1'b0, fifo_count};
    assign req             = !rst && !bus.redirect_i && (in_flight < DEPTH_LIMIT);
    assign issue           = req && bus.instr_gnt_i;
    assign resp            = bus.instr_rvalid_i;
    assign drop            = resp && (discard != '0);
    assign push            = resp && (discard == '0) && !bus.redirect_i;
    assign outstanding_nxt = outstanding + CNT_W'(issue) - CNT_W'(resp);

`ifdef FETCH_COMPRESSED_EN
    assign pc_target   = bus.redirect_pc_i & 32'hFFFF_FFFE;
`else
    assign pc_target   = bus.redirect_pc_i & 32'hFFFF_FFFC;
`endif
    assign addr_target = bus.redirect_pc_i & 32'hFFFF_FFFC;

    // ------------------------------------------------------------------
    // Aligner
    // ------------------------------------------------------------------
    logic [31:0] head_word;
    logic        is_compressed;
    logic        needs_two;
    logic [31:0] aligned;
    logic        have_words;
    logic        valid;
    logic        accept;
    logic        pop;
    logic [31:0] pc_step;

    assign head_word = fifo_mem[rd_ptr];

`ifdef FETCH_COMPRESSED_EN
    logic [PTR_W-1:0] next_ptr;
    logic [15:0]      next_lo;

    assign next_ptr = rd_ptr + PTR_W'(1);
    assign next_lo  = fifo_mem[next_ptr][15:0];

    always_comb begin
        is_compressed = 1'b0;
        needs_two     = 1'b0;
        aligned       = head_word;
        if (!pc[1]) begin
            if (head_word[1:0] != 2'b11) begin
                is_compressed = 1'b1;
                aligned       = {16'b0, head_word[15:0]};
            end
        end else if (head_word[17:16] != 2'b11) begin
            is_compressed = 1'b1;
            aligned       = {16'b0, head_word[31:16]};
        end else begin
            // 32-bit instruction straddling two words: low half sits in
            // the upper half of the head, high half in the next word.
            needs_two = 1'b1;
            aligned   = {next_lo, head_word[31:16]};
        end
    end
`else
    assign is_compressed = 1'b0;
    assign needs_two     = 1'b0;
    assign aligned       = head_word;
`endif

    assign have_words = needs_two ? (fifo_count >= CNT_W'(2))
                                  : (fifo_count >= CNT_W'(1));
    assign valid      = have_words && (discard == '0);
    assign accept     = valid && bus.fetch_ready_i && !bus.redirect_i;
    // Head is consumed whenever the instruction reaches the end of the word;
    // a straddling instruction pops only the head and leaves pc[1]=1.
    assign pop        = accept && (pc[1] || !is_compressed);
    assign pc_step    = is_compressed ? 32'd2 : 32'd4;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            req_addr    <= RESET_PC & 32'hFFFF_FFFC;
            outstanding <= '0;
            discard     <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (bus.redirect_i) begin
                pc         <= pc_target;
                req_addr   <= addr_target;
                // Everything still owed by the bus after this edge is stale.
                discard    <= outstanding_nxt;
                fifo_count <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
            end else begin
                if (issue) begin
                    req_addr <= req_addr + 32'd4;
                end
                if (accept) begin
                    pc <= pc + pc_step;
                end
                if (drop) begin
                    discard <= discard - CNT_W'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by fifo_count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.instr_rdata_i;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.instr_req_o   = req;
    assign bus.instr_addr_o  = req_addr;
    assign bus.fetch_valid_o = valid;
    assign bus.fetch_instr_o = valid ? aligned : 32'h0;
    assign bus.fetch_addr_o  = pc;

endmodule
`default_nettype wire
